bit_serial_subtractor: RTL and testbench

Multi-cycle N-bit subtractor that computes A − B − bin LSB-first, one bit per clock, through a single 1-bit full-subtract stage with a registered borrow. It sits around the team's 1-bit full subtractor. It feeds that stage x/y/bin each cycle and consumes its diff/bout, shifting results into an N-bit difference register. Operand handoff and result delivery use a start/busy/done handshake, so a controller or datapath FSM can issue subtractions without a wide ripple chain.

---
 rtl/bit_serial_subtractor.sv | 125 ++++++++++++
 tb/tb_bit_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// ============================================================================
// Module   : bit_serial_subtractor
// Brief    : LSB-first serial A - B - bin using one full-subtract stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             nb;
  logic             last;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .diff (d),
    .bout (nb)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            br   <= bin;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        RUN: begin
          // New bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts
          diff <= {d, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          br   <= nb;
          if (last) begin
            bout <= nb;
            ovf  <= br ^ nb;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_bit_serial_subtractor.sv
// ============================================================================
// Module   : tb_bit_serial_subtractor
// Brief    : Randomized self-checking bench for WIDTH=8 and WIDTH=13 instances
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_subtractor;
  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s8, bi8, s13, bi13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        busy8, done8, bout8, ovf8;
  logic        busy13, done13, bout13, ovf13;
  logic [7:0]  diff8;
  logic [12:0] diff13;

  bit_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  bit_serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(s13), .a(a13), .b(b13), .bin(bi13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .ovf(ovf13)
  );

  function automatic logic        o_busy(int w); return (w == 8) ? busy8 : busy13; endfunction
  function automatic logic        o_done(int w); return (w == 8) ? done8 : done13; endfunction
  function automatic logic        o_bout(int w); return (w == 8) ? bout8 : bout13; endfunction
  function automatic logic        o_ovf (int w); return (w == 8) ? ovf8  : ovf13;  endfunction
  function automatic logic [31:0] o_diff(int w);
    return (w == 8) ? {24'd0, diff8} : {19'd0, diff13};
  endfunction

  // Reference: plain modulo and signed-range arithmetic
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic bi, output logic [31:0] d,
                                output logic bo, output logic ov);
    longint m, half, ua, ub, sa, sb, r, lb;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'({32'd0, av}) & (m - 1);
    ub   = longint'({32'd0, bv}) & (m - 1);
    lb   = bi ? 64'sd1 : 64'sd0;
    d    = 32'((ua - ub - lb) & (m - 1));
    bo   = (ua < ub + lb);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    r    = sa - sb - lb;
    ov   = (r < -half) || (r >= half);
  endfunction

  task automatic drive(int w, logic s, logic [31:0] av, logic [31:0] bv, logic bi);
    if (w == 8) begin
      s8 = s; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bi;
    end else begin
      s13 = s; a13 = av[12:0]; b13 = bv[12:0]; bi13 = bi;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(int w, logic [31:0] av, logic [31:0] bv, logic bi, string name);
    logic [31:0] ed;
    logic        eb, eo;
    int          bad;
    model(w, av, bv, bi, ed, eb, eo);
    drive(w, 1'b1, av, bv, bi);
    tick;
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    bad = 0;
    for (int k = 1; k <= w; k++) begin
      if (o_busy(w) !== 1'b1 || o_done(w) !== 1'b0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_busy_window w=%0d: bad cycles=%0d, expected 0", name, w, bad);
    end
    checks++;
    if (o_done(w) !== 1'b1 || o_busy(w) !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_rise w=%0d: got done=%b busy=%b, expected done=1 busy=0",
               name, w, o_done(w), o_busy(w));
    end
    checks++;
    if (o_diff(w) !== ed || o_bout(w) !== eb || o_ovf(w) !== eo) begin
      errors++;
      $display("FAIL %s_result w=%0d a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b, expected diff=%h bout=%b ovf=%b",
               name, w, av, bv, bi, o_diff(w), o_bout(w), o_ovf(w), ed, eb, eo);
    end
    tick;
    checks++;
    if (o_done(w) !== 1'b0 || o_busy(w) !== 1'b0 || o_diff(w) !== ed || o_bout(w) !== eb) begin
      errors++;
      $display("FAIL %s_after_done w=%0d: got done=%b busy=%b diff=%h bout=%b, expected done=0 busy=0 diff=%h bout=%b",
               name, w, o_done(w), o_busy(w), o_diff(w), o_bout(w), ed, eb);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      int w;
      w = (i == 0) ? 8 : 13;
      checks++;
      if (o_busy(w) !== 1'b0 || o_done(w) !== 1'b0 || o_diff(w) !== 32'd0 ||
          o_bout(w) !== 1'b0 || o_ovf(w) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state w=%0d: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                 w, o_busy(w), o_done(w), o_diff(w), o_bout(w), o_ovf(w));
      end
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    run_op(8, 32'h05, 32'h03, 1'b0, "d_05_03");
    run_op(8, 32'h03, 32'h05, 1'b0, "d_03_05");
    run_op(8, 32'h80, 32'h01, 1'b0, "d_80_01");
    run_op(8, 32'h00, 32'h00, 1'b1, "d_00_00_b");
    run_op(8, 32'h7F, 32'hFF, 1'b0, "d_7f_ff");
    run_op(13, 32'h0000, 32'h1FFF, 1'b1, "d13_min");
  endtask

  task automatic test_ignored_start;
    int          pulses;
    logic [31:0] got;
    logic        got_b;
    drive(8, 1'b1, 32'h10, 32'h01, 1'b0);
    tick;
    drive(8, 1'b0, 32'h10, 32'h01, 1'b0);
    tick;
    tick;
    drive(8, 1'b1, 32'hFF, 32'h00, 1'b0);
    tick;
    drive(8, 1'b0, 32'hFF, 32'h00, 1'b0);
    pulses = 0;
    got    = '0;
    got_b  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done8 === 1'b1) begin
        pulses++;
        got   = {24'd0, diff8};
        got_b = bout8;
      end
      tick;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignored_start_pulses: got %0d done pulses, expected 1", pulses);
    end
    checks++;
    if (got !== 32'h0F || got_b !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_result: got diff=%h bout=%b, expected diff=0f bout=0", got, got_b);
    end

    // start held high across DONE is only taken once back in IDLE
    drive(8, 1'b1, 32'h30, 32'h05, 1'b1);
    tick;
    for (int k = 0; k < 8; k++) tick;
    checks++;
    if (done8 !== 1'b1 || diff8 !== 8'h2A) begin
      errors++;
      $display("FAIL held_start_first: got done=%b diff=%h, expected done=1 diff=2a", done8, diff8);
    end
    tick;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL held_start_idle: got busy=%b done=%b, expected busy=0 done=0", busy8, done8);
    end
    tick;
    drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL held_start_accept: got busy=%b, expected busy=1", busy8);
    end
    for (int k = 0; k < 8; k++) tick;
    checks++;
    if (done8 !== 1'b1 || diff8 !== 8'h2A || bout8 !== 1'b0) begin
      errors++;
      $display("FAIL held_start_second: got done=%b diff=%h bout=%b, expected done=1 diff=2a bout=0",
               done8, diff8, bout8);
    end
    tick;
  endtask

  task automatic test_reset_midrun;
    int pulses;
    drive(8, 1'b1, 32'h55, 32'h22, 1'b0);
    tick;
    drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
    for (int k = 0; k < 4; k++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
      tick;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_reset_quiet: got %0d busy/done cycles, expected 0", pulses);
    end
    run_op(8, 32'h20, 32'h10, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++)
      run_op(8, $urandom, $urandom, 1'($urandom), "rand8");
    for (int i = 0; i < 1000; i++)
      run_op(13, $urandom, $urandom, 1'($urandom), "rand13");
  endtask

  initial begin
    rst_n = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    s13 = 1'b0; a13 = '0; b13 = '0; bi13 = 1'b0;
    tick;
    tick;
    test_reset;
    test_directed;
    test_ignored_start;
    test_reset_midrun;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
